// File: rtl/decode_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The stage uses the slave modport; the fetch/execute side uses master.
interface decode_if;
    logic        InstrValid;
    logic [31:0] Instr;
    logic        InstrReady;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [10:0] Ctrl;
    logic [5:0]  Func;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] Imm;
    logic        Illegal;
    logic        MulBusy;

    modport master (
        output InstrValid, Instr, Flush, OutReady,
        input  InstrReady, OutValid, Ctrl, Func, Rs, Rt, Rd, Imm, Illegal, MulBusy
    );

    modport slave (
        input  InstrValid, Instr, Flush, OutReady,
        output InstrReady, OutValid, Ctrl, Func, Rs, Rt, Rd, Imm, Illegal, MulBusy
    );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: valid/ready pipeline register holding decoded control,
// with load-use interlock, HI/LO multiply busy tracking, flush and illegal-opcode flagging.
module decode_stage #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic     clk,
    input  logic     rst,
    decode_if.slave  bus
);

    // Ctrl = {RegDst,Branch,Jump,MemRead,MemtoReg,ALUOp,MULOp,Memwrite,ALUSrc,RegWrite,ShiftSel}
    localparam logic [10:0] C_REGDST   = 11'h400;
    localparam logic [10:0] C_BRANCH   = 11'h200;
    localparam logic [10:0] C_JUMP     = 11'h100;
    localparam logic [10:0] C_MEMREAD  = 11'h080;
    localparam logic [10:0] C_MEMTOREG = 11'h040;
    localparam logic [10:0] C_ALUOP    = 11'h020;
    localparam logic [10:0] C_MULOP    = 11'h010;
    localparam logic [10:0] C_MEMWRITE = 11'h008;
    localparam logic [10:0] C_ALUSRC   = 11'h004;
    localparam logic [10:0] C_REGWRITE = 11'h002;
    localparam logic [10:0] C_SHIFTSEL = 11'h001;
    localparam int          B_MEMREAD  = 7;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;
    localparam logic [5:0] F_JR   = 6'h08;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef struct packed {
        logic [10:0] ctrl;
        logic [5:0]  func;
        logic        illegal;
        logic        mul_class;
        logic        hilo_read;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        d  = '0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        d.ctrl = C_REGDST | C_ALUOP | C_REGWRITE;
                        d.func = fn;
                    end
                    6'h10, 6'h12: begin
                        d.ctrl      = C_REGDST | C_ALUOP | C_REGWRITE;
                        d.func      = fn;
                        d.hilo_read = 1'b1;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19: begin
                        d.ctrl      = C_ALUOP;
                        d.func      = fn;
                        d.mul_class = 1'b1;
                    end
                    6'h08: begin
                        d.ctrl = C_JUMP;
                        d.func = F_JR;
                    end
                    6'h09: begin
                        d.ctrl = C_JUMP | C_REGDST | C_REGWRITE;
                        d.func = fn;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                case (fn)
                    6'h00, 6'h01, 6'h04, 6'h05: begin
                        d.ctrl      = C_MULOP;
                        d.func      = fn;
                        d.mul_class = 1'b1;
                    end
                    6'h02: begin
                        d.ctrl      = C_MULOP | C_REGDST | C_REGWRITE;
                        d.func      = fn;
                        d.mul_class = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            6'h08: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_ADD;  end
            6'h09: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_ADDU; end
            6'h0A: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_SLT;  end
            6'h0B: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_SLTU; end
            6'h0C: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_AND;  end
            6'h0D: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_OR;   end
            6'h0E: begin d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE; d.func = F_XOR;  end
            OP_LUI: begin
                d.ctrl = C_ALUOP | C_ALUSRC | C_REGWRITE | C_SHIFTSEL;
                d.func = F_ADD;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h30: begin
                d.ctrl = C_MEMREAD | C_MEMTOREG | C_ALUSRC | C_REGWRITE;
                d.func = F_ADD;
            end
            OP_SB, OP_SH, OP_SW: begin
                d.ctrl = C_MEMWRITE | C_ALUSRC;
                d.func = F_ADD;
            end
            OP_BEQ, OP_BNE, 6'h06, 6'h07: begin
                d.ctrl = C_BRANCH;
                d.func = F_SUB;
            end
            OP_J:    d.ctrl = C_JUMP;
            OP_JAL:  d.ctrl = C_JUMP | C_REGWRITE;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic             valid_reg;
    logic [10:0]      ctrl_reg;
    logic [5:0]       func_reg;
    logic [4:0]       rs_reg;
    logic [4:0]       rt_reg;
    logic [4:0]       rd_reg;
    logic [15:0]      imm_reg;
    logic             illegal_reg;
    logic             mul_reg;
    logic [CNT_W-1:0] cnt_reg;

    dec_t       in_dec;
    logic [5:0] in_op;
    logic [4:0] in_rs;
    logic [4:0] in_rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       hazard;
    logic       mul_haz;
    logic       mul_busy;
    logic       instr_ready;
    logic       accept;
    logic       out_fire;

    assign mul_busy = (cnt_reg != '0);

    // A held load blocks any incoming instruction that reads its destination register.
    always_comb begin
        in_dec  = decode(bus.Instr);
        in_op   = bus.Instr[31:26];
        in_rs   = bus.Instr[25:21];
        in_rt   = bus.Instr[20:16];
        uses_rs = !((in_op == OP_J) || (in_op == OP_JAL) || (in_op == OP_LUI));
        uses_rt = (in_op == OP_SPECIAL) || (in_op == OP_SPECIAL2) ||
                  (in_op == OP_SB) || (in_op == OP_SH) || (in_op == OP_SW) ||
                  (in_op == OP_BEQ) || (in_op == OP_BNE);
        hazard  = valid_reg && ctrl_reg[B_MEMREAD] && (rt_reg != 5'd0) &&
                  ((uses_rs && (in_rs == rt_reg)) || (uses_rt && (in_rt == rt_reg)));
        mul_haz = mul_busy && (in_dec.mul_class || in_dec.hilo_read);
    end

    assign instr_ready = bus.Flush || (!hazard && !mul_haz && (!valid_reg || bus.OutReady));
    assign accept      = bus.InstrValid && instr_ready && !bus.Flush;
    assign out_fire    = valid_reg && bus.OutReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            func_reg    <= '0;
            rs_reg      <= '0;
            rt_reg      <= '0;
            rd_reg      <= '0;
            imm_reg     <= '0;
            illegal_reg <= 1'b0;
            mul_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            // Flush wins over a same-cycle accept: the fetched word is consumed but dropped.
            if (bus.Flush) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                valid_reg   <= 1'b1;
                ctrl_reg    <= in_dec.ctrl;
                func_reg    <= in_dec.func;
                rs_reg      <= bus.Instr[25:21];
                rt_reg      <= bus.Instr[20:16];
                rd_reg      <= bus.Instr[15:11];
                imm_reg     <= bus.Instr[15:0];
                illegal_reg <= in_dec.illegal;
                mul_reg     <= in_dec.mul_class;
            end else if (out_fire) begin
                valid_reg <= 1'b0;
            end

            if (out_fire && mul_reg) begin
                cnt_reg <= CNT_LOAD;
            end else if (mul_busy) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign bus.InstrReady = instr_ready;
    assign bus.OutValid   = valid_reg;
    assign bus.Ctrl       = ctrl_reg;
    assign bus.Func       = func_reg;
    assign bus.Rs         = rs_reg;
    assign bus.Rt         = rt_reg;
    assign bus.Rd         = rd_reg;
    assign bus.Imm        = imm_reg;
    assign bus.Illegal    = illegal_reg;
    assign bus.MulBusy    = mul_busy;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, all checked each cycle
// against a table-driven reference decoder and a transaction-level pipeline model.
module tb_decode_stage;
    localparam int MUL_CYCLES = 4;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    decode_if bus();

    decode_stage #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        legal;
        bit [10:0] ctrl;
        bit [5:0]  func;
        bit        mulc;
        bit        hilo;
    } ent_t;

    ent_t op_t[64];
    ent_t sp_t[64];
    ent_t s2_t[64];

    int n_vec;
    int n_err;

    // Pipeline model: at most one held instruction plus remaining multiply-busy cycles.
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_busy;

    bit          cur_rst, cur_v, cur_r, cur_f, exp_ready;
    logic [31:0] cur_i;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control flags by letter, in Ctrl bit order from bit 10 down to bit 0.
    function automatic bit [10:0] fl(string s);
        bit [10:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "D": v[10] = 1'b1;
                "B": v[9]  = 1'b1;
                "J": v[8]  = 1'b1;
                "R": v[7]  = 1'b1;
                "M": v[6]  = 1'b1;
                "A": v[5]  = 1'b1;
                "U": v[4]  = 1'b1;
                "W": v[3]  = 1'b1;
                "S": v[2]  = 1'b1;
                "G": v[1]  = 1'b1;
                "H": v[0]  = 1'b1;
                default: ;
            endcase
        end
        return v;
    endfunction

    task automatic put(int tbl, int code, string f, int func, bit mulc = 1'b0, bit hilo = 1'b0);
        ent_t e;
        e.legal = 1'b1;
        e.ctrl  = fl(f);
        e.func  = 6'(func);
        e.mulc  = mulc;
        e.hilo  = hilo;
        case (tbl)
            0:       op_t[code] = e;
            1:       sp_t[code] = e;
            default: s2_t[code] = e;
        endcase
    endtask

    task automatic build_tables();
        ent_t z;
        int alu_fn[16] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h20, 'h21,
                           'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
        int ld_op[6] = '{'h20, 'h21, 'h23, 'h24, 'h25, 'h30};
        z.legal = 1'b0; z.ctrl = '0; z.func = '0; z.mulc = 1'b0; z.hilo = 1'b0;
        for (int i = 0; i < 64; i++) begin
            op_t[i] = z; sp_t[i] = z; s2_t[i] = z;
        end
        for (int i = 0; i < 16; i++) put(1, alu_fn[i], "DAG", alu_fn[i]);
        put(1, 'h08, "J", 'h08);
        put(1, 'h09, "JDG", 'h09);
        put(1, 'h10, "DAG", 'h10, 1'b0, 1'b1);
        put(1, 'h12, "DAG", 'h12, 1'b0, 1'b1);
        put(1, 'h11, "A", 'h11, 1'b1);
        put(1, 'h13, "A", 'h13, 1'b1);
        put(1, 'h18, "A", 'h18, 1'b1);
        put(1, 'h19, "A", 'h19, 1'b1);
        put(2, 'h00, "U", 'h00, 1'b1);
        put(2, 'h01, "U", 'h01, 1'b1);
        put(2, 'h04, "U", 'h04, 1'b1);
        put(2, 'h05, "U", 'h05, 1'b1);
        put(2, 'h02, "UDG", 'h02, 1'b1);
        put(0, 'h08, "ASG", 'h20);
        put(0, 'h09, "ASG", 'h21);
        put(0, 'h0C, "ASG", 'h24);
        put(0, 'h0D, "ASG", 'h25);
        put(0, 'h0E, "ASG", 'h26);
        put(0, 'h0A, "ASG", 'h2A);
        put(0, 'h0B, "ASG", 'h2B);
        put(0, 'h0F, "ASGH", 'h20);
        for (int i = 0; i < 6; i++) put(0, ld_op[i], "RMSG", 'h20);
        put(0, 'h28, "WS", 'h20);
        put(0, 'h29, "WS", 'h20);
        put(0, 'h2B, "WS", 'h20);
        for (int i = 4; i < 8; i++) put(0, i, "B", 'h22);
        put(0, 'h02, "J", 0);
        put(0, 'h03, "JG", 0);
    endtask

    function automatic ent_t ref_dec(logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        if (op == 0)         return sp_t[fn];
        else if (op == 'h1C) return s2_t[fn];
        else                 return op_t[op];
    endfunction

    function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
        int op = int'(ins[31:26]);
        bit use_rs = !(op == 'h02 || op == 'h03 || op == 'h0F);
        bit use_rt = (op == 'h00 || op == 'h1C || op == 'h28 || op == 'h29 ||
                      op == 'h2B || op == 'h04 || op == 'h05);
        return (use_rs && ins[25:21] == r) || (use_rt && ins[20:16] == r);
    endfunction

    task automatic apply(bit r, bit v, logic [31:0] ins, bit ordy, bit f);
        ent_t eh, ei;
        bit   haz, mhaz;
        @(negedge clk);
        rst = r; bus.InstrValid = v; bus.Instr = ins; bus.OutReady = ordy; bus.Flush = f;
        cur_rst = r; cur_v = v; cur_i = ins; cur_r = ordy; cur_f = f;
        #1;
        eh   = ref_dec(m_instr);
        ei   = ref_dec(ins);
        haz  = m_valid && eh.legal && eh.ctrl[7] && (m_instr[20:16] != 5'd0) &&
               reads_reg(ins, m_instr[20:16]);
        mhaz = (m_busy != 0) && (ei.mulc || ei.hilo);
        exp_ready = f || (!haz && !mhaz && (!m_valid || ordy));
        chk("InstrReady", 32'(bus.InstrReady), 32'(exp_ready));
        chk("OutValid", 32'(bus.OutValid), 32'(m_valid));
        chk("MulBusy", 32'(bus.MulBusy), 32'(m_busy != 0));
        if (m_valid) begin
            chk("Ctrl", 32'(bus.Ctrl), 32'(eh.ctrl));
            chk("Func", 32'(bus.Func), 32'(eh.func));
            chk("Illegal", 32'(bus.Illegal), 32'(!eh.legal));
            chk("Rs", 32'(bus.Rs), 32'(m_instr[25:21]));
            chk("Rt", 32'(bus.Rt), 32'(m_instr[20:16]));
            chk("Rd", 32'(bus.Rd), 32'(m_instr[15:11]));
            chk("Imm", 32'(bus.Imm), 32'(m_instr[15:0]));
        end
    endtask

    task automatic commit();
        bit   fire;
        ent_t eh;
        @(posedge clk);
        if (cur_rst) begin
            m_valid = 1'b0;
            m_busy  = 0;
        end else begin
            fire = m_valid && cur_r;
            eh   = ref_dec(m_instr);
            if (fire) $display("xfer instr=%08h illegal=%0d", m_instr, !eh.legal);
            if (fire && eh.mulc) m_busy = MUL_CYCLES - 1;
            else if (m_busy > 0) m_busy--;
            if (cur_f)                       m_valid = 1'b0;
            else if (cur_v && exp_ready) begin m_valid = 1'b1; m_instr = cur_i; end
            else if (fire)                   m_valid = 1'b0;
        end
    endtask

    task automatic cyc(bit r, bit v, logic [31:0] ins, bit ordy, bit f);
        apply(r, v, ins, ordy, f);
        commit();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] pool[32] = '{
            32'h00000020, 32'h00000022, 32'h00000000, 32'h00000008, 32'h00000009,
            32'h00000010, 32'h00000012, 32'h00000011, 32'h00000018, 32'h00000019,
            32'h0000001A, 32'h0000000C, 32'h70000000, 32'h70000002, 32'h70000021,
            32'h70000004, 32'h20000000, 32'h3C000000, 32'h34000000, 32'h8C000000,
            32'h8C000000, 32'h8C000000, 32'h80000000, 32'hAC000000, 32'hA0000000,
            32'h10000000, 32'h18000000, 32'h08000000, 32'h0C000000, 32'h88000000,
            32'hE0000000, 32'hFC000000};
        logic [31:0] t;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        t  = pool[$urandom_range(0, 31)];
        op = t[31:26];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (op == 6'h00 || op == 6'h1C) return {op, rs, rt, rd, 5'($urandom_range(0, 31)), t[5:0]};
        return {op, rs, rt, 16'($urandom)};
    endfunction

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_OR   = 32'h00221825;
    localparam logic [31:0] I_LW   = 32'h8C250000;
    localparam logic [31:0] I_ADD5 = 32'h00A13020;
    localparam logic [31:0] I_ADD0 = 32'h00013020;
    localparam logic [31:0] I_MULT = 32'h00220018;
    localparam logic [31:0] I_MFLO = 32'h00002012;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_CLZ  = 32'h70221820;

    initial begin
        n_vec = 0; n_err = 0;
        m_valid = 1'b0; m_instr = '0; m_busy = 0;
        rst = 1'b1;
        bus.InstrValid = 1'b0; bus.Instr = '0; bus.OutReady = 1'b0; bus.Flush = 1'b0;
        build_tables();

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        chk("rst_valid", 32'(bus.OutValid), 0);
        chk("rst_ctrl", 32'(bus.Ctrl), 0);
        chk("rst_func", 32'(bus.Func), 0);
        chk("rst_fields", {bus.Rs, bus.Rt, bus.Rd, bus.Imm}, 0);
        chk("rst_flags", {bus.Illegal, bus.MulBusy}, 0);
        commit();

        // ADD $3,$1,$2: one-cycle latency, RegDst|ALUOp|RegWrite
        cyc(0, 1, I_ADD, 1, 0);
        apply(0, 0, 0, 1, 0);
        chk("add_valid", 32'(bus.OutValid), 1);
        chk("add_ctrl", 32'(bus.Ctrl), 32'h422);
        chk("add_func", 32'(bus.Func), 32'h20);
        chk("add_regs", {bus.Rs, bus.Rt, bus.Rd}, {5'd1, 5'd2, 5'd3});
        commit();

        // Load-use: exactly one bubble after the load leaves
        cyc(0, 1, I_LW, 1, 0);
        apply(0, 1, I_ADD5, 0, 0); chk("lu_hold", 32'(bus.InstrReady), 0); commit();
        apply(0, 1, I_ADD5, 1, 0); chk("lu_leave", 32'(bus.InstrReady), 0); commit();
        apply(0, 1, I_ADD5, 1, 0);
        chk("lu_bubble", 32'(bus.OutValid), 0);
        chk("lu_accept", 32'(bus.InstrReady), 1);
        commit();
        apply(0, 0, 0, 1, 0);
        chk("lu_add", 32'(bus.OutValid), 1);
        chk("lu_add_rs", 32'(bus.Rs), 5);
        commit();
        cyc(0, 1, I_LW, 1, 0);
        apply(0, 1, I_ADD0, 1, 0); chk("lu_rs0", 32'(bus.InstrReady), 1); commit();
        apply(0, 0, 0, 1, 0);
        chk("lu_rs0_valid", 32'(bus.OutValid), 1);
        chk("lu_rs0_rd", 32'(bus.Rd), 6);
        commit();

        // MULT then MFLO: busy for MUL_CYCLES-1 cycles after issue
        cyc(0, 1, I_MULT, 1, 0);
        apply(0, 0, 0, 1, 0); chk("mul_issue_busy", 32'(bus.MulBusy), 0); commit();
        for (int i = 0; i < MUL_CYCLES - 1; i++) begin
            apply(0, 1, I_MFLO, 1, 0);
            chk("mfl_busy", 32'(bus.MulBusy), 1);
            chk("mfl_stall", 32'(bus.InstrReady), 0);
            commit();
        end
        apply(0, 1, I_MFLO, 1, 0);
        chk("mfl_free", 32'(bus.MulBusy), 0);
        chk("mfl_ready", 32'(bus.InstrReady), 1);
        commit();
        apply(0, 0, 0, 1, 0); chk("mfl_func", 32'(bus.Func), 32'h12); commit();

        // Backpressure: outputs hold, then drain with back-to-back successor
        cyc(0, 1, I_ADD, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, I_SUB, 0, 0);
            chk("stall_ready", 32'(bus.InstrReady), 0);
            chk("stall_func", 32'(bus.Func), 32'h20);
            commit();
        end
        cyc(0, 1, I_SUB, 1, 0);
        apply(0, 0, 0, 1, 0);
        chk("b2b_valid", 32'(bus.OutValid), 1);
        chk("b2b_func", 32'(bus.Func), 32'h22);
        commit();

        // Flush beats accept
        cyc(0, 1, I_ADD, 0, 0);
        apply(0, 1, I_OR, 0, 1); chk("flush_ready", 32'(bus.InstrReady), 1); commit();
        apply(0, 0, 0, 1, 0); chk("flush_kill", 32'(bus.OutValid), 0); commit();
        apply(0, 0, 0, 1, 0); chk("flush_gone", 32'(bus.OutValid), 0); commit();

        // Illegal encodings still pass through
        cyc(0, 1, I_BAD, 1, 0);
        apply(0, 1, I_CLZ, 1, 0);
        chk("ill_op_valid", 32'(bus.OutValid), 1);
        chk("ill_op_flag", 32'(bus.Illegal), 1);
        chk("ill_op_ctrl", 32'(bus.Ctrl), 0);
        commit();
        apply(0, 0, 0, 1, 0);
        chk("ill_clz_flag", 32'(bus.Illegal), 1);
        chk("ill_clz_ctrl", 32'(bus.Ctrl), 0);
        commit();

        // Reset in the middle of a stall
        cyc(0, 1, I_ADD, 0, 0);
        cyc(0, 1, I_SUB, 0, 0);
        cyc(1, 1, I_SUB, 0, 0);
        apply(0, 0, 0, 0, 0);
        chk("rst2_valid", 32'(bus.OutValid), 0);
        chk("rst2_ctrl", 32'(bus.Ctrl), 0);
        chk("rst2_fields", {bus.Rs, bus.Rt, bus.Rd, bus.Imm}, 0);
        chk("rst2_func", 32'(bus.Func), 0);
        commit();

        for (int n = 0; n < 2000; n++) begin
            cyc(0, $urandom_range(0, 3) != 0, rnd_instr(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
